memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes `control_mem_s`, the ALU result (the effective address for memory ops) and the store data.
- Performs LB/LH/LW/LBU/LHU/SB/SH/SW against a variable-latency data-memory port using a req/gnt/rvalid handshake.
- Hands a registered `control_wb_s` plus result to writeback, and stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath width (must match `rapid_pkg::XLEN`).
- MAX_WAIT, 255, cycles allowed in REQ+WAIT before the access is aborted as a bus error (8-bit counter).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  execute output valid
- o_ready  out  1  stage can accept; high only in IDLE
- i_control_signal  in  control_mem_s  mem, iop (1=store), fcs_opcode, rd, debug_instruction
- i_rd_output  in  XLEN  ALU result / effective address
- i_memory_data  in  XLEN  store data (rs2)
- o_dmem_req  out  1  request valid
- o_dmem_we  out  1  1=write
- o_dmem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- o_dmem_be  out  4  byte enables
- o_dmem_wdata  out  XLEN  lane-replicated write data
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  XLEN  read word
- o_valid  out  1  result valid to writeback, one-cycle pulse
- o_control_signal  out  control_wb_s  rd, debug_instruction
- o_rd_data  out  XLEN  value for rd
- o_misaligned  out  1  alignment fault, qualified by o_valid
- o_bus_error  out  1  timeout fault, qualified by o_valid

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0.
  - o_ready=1 in the first cycle after reset deasserts.
- Acceptance: occurs on i_valid && o_ready; all inputs are captured into internal registers.
- Size decode: fcs[1:0] 00=byte, 01=half, 1x=word; fcs[2]=1 zero-extend, else sign-extend.
- Non-memory op (mem=0):
  - o_valid the cycle after acceptance.
  - o_rd_data = captured i_rd_output; rd passed through.
  - State stays IDLE (full throughput).
- Misalignment check (memory op):
  - Faults are half with addr[0]=1, or word with addr[1:0]≠00.
  - On a fault: no dmem request; o_valid and o_misaligned the next cycle; o_control_signal.rd forced to 0 (write suppressed).
- FSM states IDLE, REQ, WAIT:
  - IDLE -> REQ on an accepted, aligned memory op. o_dmem_req=1 from the next cycle.
  - REQ: addr/we/be/wdata held stable until i_dmem_gnt.
    - Store + gnt -> IDLE; o_valid next cycle; rd forced 0.
    - Load + gnt -> WAIT. If i_dmem_rvalid arrives in the same cycle as gnt, it is the response: go to IDLE directly.
  - WAIT: on i_dmem_rvalid, extract, extend and register the result; o_valid next cycle; -> IDLE.
  - o_dmem_req deasserts in the cycle after gnt.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be=4'b0011<<addr[1:0].
  - SW: wdata=d, be=4'b1111.
- Load extract: rdata>>(8*addr[1:0]), then the low 8/16/32 bits are extended per fcs[2].
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - At MAX_WAIT: abort to IDLE; o_valid and o_bus_error next cycle; rd forced 0; req dropped.
- Stray responses: rvalid in IDLE or REQ without gnt is ignored.
- Latency:
  - Non-mem: 1 cycle.
  - Zero-wait load: accept N, req N+1 with gnt, rvalid N+2, o_valid N+3.
- Reset mid-transaction: returns to IDLE, drops req next cycle, no o_valid for the abandoned op, later rvalid ignored.

Decomposition:
- rapid_pkg additions:
  - control_wb_s (rd, debug_instruction).
  - mem_size_e (BYTE, HALF, WORD).
  - mem_state_e (IDLE, REQ, WAIT).
  - MEM_MAX_WAIT constant.
- Sub-module: load_store_align, combinational.
  - Inputs: size, unsigned, addr[1:0], store data, read data.
  - Outputs: be, wdata, extended load value, misaligned.

Test Plan:
- ADD result 0x0000_1234, mem=0 -> o_valid next cycle, o_rd_data=0x1234, no dmem_req, back-to-back ops each 1 cycle.
- SB d=0xAABB_CCDD at addr 0x103, gnt immediately -> addr=0x100, be=4'b1000, wdata=0xDDDD_DDDD, o_valid rd=0.
- LH at 0x202, rdata=0x8001_0000, gnt 3 cycles late, rvalid 2 cycles later -> o_rd_data=0xFFFF_8001; LHU -> 0x0000_8001; o_ready low throughout.
- LW at 0x305 -> no req, o_misaligned=1 with o_valid, rd=0; SH at 0x101 likewise.
- Load with gnt and no rvalid for 255 cycles -> o_bus_error=1, req low, subsequent stray rvalid ignored.
- i_rst asserted in WAIT -> req low next cycle, no o_valid, o_ready=1 after reset; following LB at 0x0 with rdata 0x0000_0080 -> 0xFFFF_FF80.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage.
// Holds the execute->mem and mem->writeback control bundles, the access-size
// and FSM state encodings, the datapath width and the default bus timeout.
package memory_access_pkg;

  localparam int XLEN         = 32;
  localparam int MEM_MAX_WAIT = 255;

  typedef struct packed {
    logic        mem;                // instruction touches data memory
    logic        iop;                // 1 = store, 0 = load
    logic [2:0]  fcs_opcode;         // [1:0] size, [2] zero-extend
    logic [4:0]  rd;
    logic [31:0] debug_instruction;
  } control_mem_s;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] debug_instruction;
  } control_wb_s;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_REQ  = 2'b01,
    MEM_WAIT = 2'b10
  } mem_state_e;

  // fcs[1:0]: 00 byte, 01 half, 1x word
  function automatic mem_size_e decode_size(input logic [1:0] fcs);
    mem_size_e size;
    case (fcs)
      2'b00:   size = MEM_BYTE;
      2'b01:   size = MEM_HALF;
      default: size = MEM_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-memory port bundle (req/gnt/rvalid handshake).
//   req/we/addr/be/wdata : driven by the requester (master)
//   gnt/rvalid/rdata     : driven by the memory (slave)
interface memory_access_if;
  import memory_access_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/memory_access_load_store_align.sv
// Combinational byte-lane logic for loads and stores.
//   i_size/i_unsigned/i_addr_lo : access shape
//   i_store_data -> o_be, o_wdata (lane-replicated store)
//   i_read_data  -> o_load_value (shifted and extended)
//   o_misaligned : half on odd address or word not on a 4-byte boundary
module memory_access_load_store_align
  import memory_access_pkg::*;
#(
  parameter int XLEN = memory_access_pkg::XLEN
) (
  input  mem_size_e       i_size,
  input  logic            i_unsigned,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_read_data,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_value,
  output logic            o_misaligned
);

  logic [XLEN-1:0] shifted_s;
  logic            sign_fill_s;

  // Lane selection, replication and load extension per access size
  always_comb begin
    shifted_s    = i_read_data >> {i_addr_lo, 3'b000};
    sign_fill_s  = 1'b0;
    o_be         = 4'b0000;
    o_wdata      = '0;
    o_load_value = '0;
    o_misaligned = 1'b0;
    case (i_size)
      MEM_BYTE: begin
        sign_fill_s  = shifted_s[7] & ~i_unsigned;
        o_be         = 4'b0001 << i_addr_lo;
        o_wdata      = {4{i_store_data[7:0]}};
        o_load_value = {{(XLEN-8){sign_fill_s}}, shifted_s[7:0]};
        o_misaligned = 1'b0;
      end
      MEM_HALF: begin
        sign_fill_s  = shifted_s[15] & ~i_unsigned;
        o_be         = 4'b0011 << i_addr_lo;
        o_wdata      = {2{i_store_data[15:0]}};
        o_load_value = {{(XLEN-16){sign_fill_s}}, shifted_s[15:0]};
        o_misaligned = i_addr_lo[0];
      end
      MEM_WORD: begin
        o_be         = 4'b1111;
        o_wdata      = i_store_data;
        o_load_value = shifted_s;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: begin
        o_be         = 4'b0000;
        o_wdata      = '0;
        o_load_value = '0;
        o_misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage.
//   i_valid/o_ready           : handshake with execute (ready only in IDLE)
//   i_control_signal, i_rd_output (address / ALU result), i_memory_data (store data)
//   dmem                      : data-memory req/gnt/rvalid port (master side)
//   o_valid (1-cycle pulse), o_control_signal, o_rd_data, o_misaligned, o_bus_error
module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN     = memory_access_pkg::XLEN,
  parameter int MAX_WAIT = memory_access_pkg::MEM_MAX_WAIT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  control_mem_s           i_control_signal,
  input  logic [XLEN-1:0]        i_rd_output,
  input  logic [XLEN-1:0]        i_memory_data,
  memory_access_if.master        dmem,
  output logic                   o_valid,
  output control_wb_s            o_control_signal,
  output logic [XLEN-1:0]        o_rd_data,
  output logic                   o_misaligned,
  output logic                   o_bus_error
);

  // Same encoding as mem_state_e
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_WAIT = 2'b10;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [1:0]      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            iop_q, iop_d;
  logic [2:0]      fcs_q, fcs_d;
  logic [4:0]      rd_q, rd_d;
  logic [31:0]     dbg_q, dbg_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            valid_q, valid_d;
  control_wb_s     wb_q, wb_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            mis_q, mis_d;
  logic            berr_q, berr_d;

  mem_size_e       al_size_s;
  logic            al_unsigned_s;
  logic [1:0]      al_addr_lo_s;
  logic [3:0]      al_be_s;
  logic [XLEN-1:0] al_wdata_s;
  logic [XLEN-1:0] al_load_s;
  logic            al_mis_s;
  logic            accept_s;

  // The aligner serves the incoming op while idle and the captured op while busy
  always_comb begin
    if (state_q == ST_IDLE) begin
      al_size_s     = decode_size(i_control_signal.fcs_opcode[1:0]);
      al_unsigned_s = i_control_signal.fcs_opcode[2];
      al_addr_lo_s  = i_rd_output[1:0];
    end else begin
      al_size_s     = decode_size(fcs_q[1:0]);
      al_unsigned_s = fcs_q[2];
      al_addr_lo_s  = addr_lo_q;
    end
  end

  memory_access_load_store_align #(.XLEN(XLEN)) u_align (
    .i_size       (al_size_s),
    .i_unsigned   (al_unsigned_s),
    .i_addr_lo    (al_addr_lo_s),
    .i_store_data (i_memory_data),
    .i_read_data  (dmem.rdata),
    .o_be         (al_be_s),
    .o_wdata      (al_wdata_s),
    .o_load_value (al_load_s),
    .o_misaligned (al_mis_s)
  );

  assign accept_s = i_valid && (state_q == ST_IDLE);

  // FSM, capture registers and writeback result
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iop_d     = iop_q;
    fcs_d     = fcs_q;
    rd_d      = rd_q;
    dbg_d     = dbg_q;
    addr_lo_d = addr_lo_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    valid_d   = 1'b0;
    wb_d      = wb_q;
    rd_data_d = rd_data_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          iop_d     = i_control_signal.iop;
          fcs_d     = i_control_signal.fcs_opcode;
          rd_d      = i_control_signal.rd;
          dbg_d     = i_control_signal.debug_instruction;
          addr_lo_d = i_rd_output[1:0];
          if (!i_control_signal.mem) begin
            valid_d   = 1'b1;
            wb_d      = '{rd: i_control_signal.rd,
                          debug_instruction: i_control_signal.debug_instruction};
            rd_data_d = i_rd_output;
          end else if (al_mis_s) begin
            // Fault without touching the bus; rd=0 suppresses the write
            valid_d   = 1'b1;
            mis_d     = 1'b1;
            wb_d      = '{rd: 5'd0,
                          debug_instruction: i_control_signal.debug_instruction};
            rd_data_d = '0;
          end else begin
            state_d = ST_REQ;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = i_control_signal.iop;
            addr_d  = {i_rd_output[XLEN-1:2], 2'b00};
            be_d    = al_be_s;
            wdata_d = i_control_signal.iop ? al_wdata_s : '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem.gnt) begin
          req_d = 1'b0;
          if (iop_q) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b1;
            wb_d      = '{rd: 5'd0, debug_instruction: dbg_q};
            rd_data_d = '0;
          end else if (dmem.rvalid) begin
            // Response arriving together with the grant belongs to this request
            state_d   = ST_IDLE;
            valid_d   = 1'b1;
            wb_d      = '{rd: rd_q, debug_instruction: dbg_q};
            rd_data_d = al_load_s;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_q + 8'd1;
          end
        end else if (cnt_q == MAX_WAIT_C) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          valid_d   = 1'b1;
          berr_d    = 1'b1;
          wb_d      = '{rd: 5'd0, debug_instruction: dbg_q};
          rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (dmem.rvalid) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b1;
          wb_d      = '{rd: rd_q, debug_instruction: dbg_q};
          rd_data_d = al_load_s;
        end else if (cnt_q == MAX_WAIT_C) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b1;
          berr_d    = 1'b1;
          wb_d      = '{rd: 5'd0, debug_instruction: dbg_q};
          rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      iop_q     <= 1'b0;
      fcs_q     <= 3'd0;
      rd_q      <= 5'd0;
      dbg_q     <= 32'd0;
      addr_lo_q <= 2'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'd0;
      wdata_q   <= '0;
      valid_q   <= 1'b0;
      wb_q      <= '0;
      rd_data_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iop_q     <= iop_d;
      fcs_q     <= fcs_d;
      rd_q      <= rd_d;
      dbg_q     <= dbg_d;
      addr_lo_q <= addr_lo_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      valid_q   <= valid_d;
      wb_q      <= wb_d;
      rd_data_q <= rd_data_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign o_ready          = (state_q == ST_IDLE);
  assign dmem.req         = req_q;
  assign dmem.we          = we_q;
  assign dmem.addr        = addr_q;
  assign dmem.be          = be_q;
  assign dmem.wdata       = wdata_q;
  assign o_valid          = valid_q;
  assign o_control_signal = wb_q;
  assign o_rd_data        = rd_data_q;
  assign o_misaligned     = mis_q;
  assign o_bus_error      = berr_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_memory_access;
  import memory_access_pkg::*;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  control_mem_s i_control_signal;
  logic [31:0]  i_rd_output;
  logic [31:0]  i_memory_data;
  logic         o_valid;
  control_wb_s  o_control_signal;
  logic [31:0]  o_rd_data;
  logic         o_misaligned;
  logic         o_bus_error;

  int n_checks = 0;
  int n_errors = 0;

  memory_access_if dmem_if ();

  memory_access dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_control_signal (i_control_signal),
    .i_rd_output      (i_rd_output),
    .i_memory_data    (i_memory_data),
    .dmem             (dmem_if.master),
    .o_valid          (o_valid),
    .o_control_signal (o_control_signal),
    .o_rd_data        (o_rd_data),
    .o_misaligned     (o_misaligned),
    .o_bus_error      (o_bus_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] fcs, input int unsigned off,
                                           input logic [31:0] rdata);
    int unsigned w, v;
    w = rdata >> (8 * off);
    if (fcs[1]) return w;
    if (!fcs[0]) begin
      v = w % 256;
      if (!fcs[2] && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = w % 65536;
      if (!fcs[2] && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] fcs, input int unsigned off);
    if (fcs[1]) return 4'hF;
    if (fcs[0]) return 4'(3 << off);
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] fcs, input logic [31:0] d);
    if (fcs[1]) return d;
    if (fcs[0]) return (d % 65536) * 32'h0001_0001;
    return (d % 256) * 32'h0101_0101;
  endfunction

  function automatic bit ref_mis(input logic [2:0] fcs, input int unsigned off);
    if (fcs[1]) return off != 0;
    if (fcs[0]) return (off % 2) == 1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive_op(input logic mem, input logic iop, input logic [2:0] fcs,
                          input logic [4:0] rd, input logic [31:0] dbg,
                          input logic [31:0] addr, input logic [31:0] sdata);
    i_valid                            = 1'b1;
    i_control_signal.mem               = mem;
    i_control_signal.iop               = iop;
    i_control_signal.fcs_opcode        = fcs;
    i_control_signal.rd                = rd;
    i_control_signal.debug_instruction = dbg;
    i_rd_output                        = addr;
    i_memory_data                      = sdata;
  endtask

  // One complete operation; gdly = cycles before gnt, rdly = cycles from gnt to rvalid
  task automatic run_op(input logic mem, input logic iop, input logic [2:0] fcs,
                        input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int gdly, input int rdly);
    logic [31:0] dbg;
    int unsigned off;
    dbg = $urandom;
    off = addr % 4;
    check("ready_before_op", o_ready, 1'b1);
    drive_op(mem, iop, fcs, rd, dbg, addr, sdata);
    step();
    i_valid = 1'b0;
    if (!mem) begin
      check("alu_valid", o_valid, 1'b1);
      check("alu_data", o_rd_data, addr);
      check("alu_rd", o_control_signal.rd, rd);
      check("alu_no_req", dmem_if.req, 1'b0);
    end else if (ref_mis(fcs, off)) begin
      check("mis_valid", o_valid, 1'b1);
      check("mis_flag", o_misaligned, 1'b1);
      check("mis_rd0", o_control_signal.rd, 5'd0);
      check("mis_dbg", o_control_signal.debug_instruction, dbg);
      check("mis_no_req", dmem_if.req, 1'b0);
      check("mis_no_berr", o_bus_error, 1'b0);
    end else begin
      for (int k = 0; k <= gdly; k++) begin
        check("req_high", dmem_if.req, 1'b1);
        check("req_addr", dmem_if.addr, addr - off);
        check("req_we", dmem_if.we, iop);
        check("req_be", dmem_if.be, ref_be(fcs, off));
        if (iop) check("req_wdata", dmem_if.wdata, ref_wdata(fcs, sdata));
        check("req_not_ready", o_ready, 1'b0);
        check("req_no_valid", o_valid, 1'b0);
        if (k == gdly) begin
          dmem_if.gnt    = 1'b1;
          dmem_if.rvalid = (!iop && rdly == 0);
          dmem_if.rdata  = (!iop && rdly == 0) ? rdata : 32'($urandom);
        end else begin
          dmem_if.gnt    = 1'b0;
          dmem_if.rvalid = 1'($urandom % 2);   // stray, must be ignored
          dmem_if.rdata  = $urandom;
        end
        step();
        dmem_if.gnt    = 1'b0;
        dmem_if.rvalid = 1'b0;
        dmem_if.rdata  = $urandom;
      end
      if (!iop) begin
        for (int j = 1; j <= rdly; j++) begin
          check("wait_req_low", dmem_if.req, 1'b0);
          check("wait_not_ready", o_ready, 1'b0);
          check("wait_no_valid", o_valid, 1'b0);
          if (j == rdly) begin
            dmem_if.rvalid = 1'b1;
            dmem_if.rdata  = rdata;
          end
          step();
          dmem_if.rvalid = 1'b0;
          dmem_if.rdata  = $urandom;
        end
      end
      check("mem_valid", o_valid, 1'b1);
      check("mem_no_mis", o_misaligned, 1'b0);
      check("mem_no_berr", o_bus_error, 1'b0);
      check("mem_req_low", dmem_if.req, 1'b0);
      check("mem_rd", o_control_signal.rd, iop ? 5'd0 : rd);
      check("mem_dbg", o_control_signal.debug_instruction, dbg);
      if (!iop) check("load_data", o_rd_data, ref_load(fcs, off, rdata));
    end
    step();
    check("valid_pulse", o_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    i_rst            = 1'b1;
    i_valid          = 1'b0;
    i_control_signal = '0;
    i_rd_output      = 32'd0;
    i_memory_data    = 32'd0;
    dmem_if.gnt      = 1'b0;
    dmem_if.rvalid   = 1'b0;
    dmem_if.rdata    = 32'd0;
    repeat (3) step();
    check("rst_valid", o_valid, 1'b0);
    check("rst_req", dmem_if.req, 1'b0);
    check("rst_rd_data", o_rd_data, 32'd0);
    check("rst_berr", o_bus_error, 1'b0);
    i_rst = 1'b0;
    step();
    check("rst_ready", o_ready, 1'b1);
    check("rst_mis", o_misaligned, 1'b0);

    // Back-to-back ALU results, one per cycle
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b0, 1'b0, 3'b010, 5'(i + 3), 32'h0, 32'h0000_1234 + 32'(i), 32'h0);
      step();
      check("b2b_valid", o_valid, 1'b1);
      check("b2b_data", o_rd_data, 32'h0000_1234 + 32'(i));
      check("b2b_ready", o_ready, 1'b1);
      check("b2b_no_req", dmem_if.req, 1'b0);
    end
    i_valid = 1'b0;
    step();

    // Directed cases
    run_op(1'b1, 1'b1, 3'b000, 5'd7, 32'h0000_0103, 32'hAABB_CCDD, 32'h0, 0, 0);  // SB
    run_op(1'b1, 1'b0, 3'b001, 5'd9, 32'h0000_0202, 32'h0, 32'h8001_0000, 3, 2);  // LH
    run_op(1'b1, 1'b0, 3'b101, 5'd9, 32'h0000_0202, 32'h0, 32'h8001_0000, 3, 2);  // LHU
    run_op(1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_0305, 32'h0, 32'h0, 0, 0);          // LW mis
    run_op(1'b1, 1'b1, 3'b001, 5'd4, 32'h0000_0101, 32'h1234_5678, 32'h0, 0, 0);  // SH mis
    run_op(1'b1, 1'b0, 3'b010, 5'd5, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0, 1);  // LW zero-wait
    check("lh_const", ref_load(3'b001, 2, 32'h8001_0000), 32'hFFFF_8001);

    // Timeout: gnt immediately, rvalid never
    drive_op(1'b1, 1'b0, 3'b010, 5'd6, 32'h0, 32'h0000_0500, 32'h0);
    step();
    i_valid     = 1'b0;
    dmem_if.gnt = 1'b1;
    step();
    dmem_if.gnt = 1'b0;
    n = 0;
    while (!o_valid && n < 400) begin
      step();
      n++;
    end
    check("to_valid_seen", o_valid, 1'b1);
    check("to_window", (n >= 250 && n <= 260), 1'b1);
    check("to_berr", o_bus_error, 1'b1);
    check("to_rd0", o_control_signal.rd, 5'd0);
    check("to_req_low", dmem_if.req, 1'b0);
    dmem_if.rvalid = 1'b1;
    dmem_if.rdata  = 32'h1111_1111;
    step();
    dmem_if.rvalid = 1'b0;
    check("stray_no_valid", o_valid, 1'b0);
    step();
    check("stray_no_valid2", o_valid, 1'b0);
    check("stray_ready", o_ready, 1'b1);

    // Reset while waiting for rvalid
    drive_op(1'b1, 1'b0, 3'b010, 5'd8, 32'h0, 32'h0000_0600, 32'h0);
    step();
    i_valid     = 1'b0;
    dmem_if.gnt = 1'b1;
    step();
    dmem_if.gnt = 1'b0;
    i_rst       = 1'b1;
    step();
    check("mid_rst_req", dmem_if.req, 1'b0);
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    i_rst          = 1'b0;
    dmem_if.rvalid = 1'b1;
    dmem_if.rdata  = 32'h2222_2222;
    step();
    dmem_if.rvalid = 1'b0;
    check("post_rst_no_valid", o_valid, 1'b0);
    run_op(1'b1, 1'b0, 3'b000, 5'd10, 32'h0000_0000, 32'h0, 32'h0000_0080, 0, 1); // LB

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom % 4 != 0), 1'($urandom % 2), 3'($urandom), 5'($urandom),
             32'($urandom), 32'($urandom), 32'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
